// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole mole scheduler.
//   mole_state_t     : scheduler FSM states
//   DIFF_*           : difficulty_level encodings
//   DEF_*            : default timing constants (milliseconds / ticks)
//   LFSR_TAPS        : Galois feedback mask for the 16-bit hole picker
//   MS_W             : width of the millisecond counter
// -----------------------------------------------------------------------------
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GAP     = 2'd1,
        UP      = 2'd2,
        WHACKED = 2'd3
    } mole_state_t;

    localparam logic [1:0] DIFF_EASY = 2'd0;
    localparam logic [1:0] DIFF_MED  = 2'd1;
    localparam logic [1:0] DIFF_HARD = 2'd2;

    localparam int DEF_TICKS_PER_MS = 100000;
    localparam int DEF_UP_MS_EASY   = 1200;
    localparam int DEF_UP_MS_MED    = 800;
    localparam int DEF_UP_MS_HARD   = 500;
    localparam int DEF_GAP_MS       = 300;
    localparam int DEF_WHACK_MS     = 150;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Every duration must fit this counter (max 2047 ms).
    localparam int MS_W = 11;

endpackage

// File: rtl/mole_scheduler_if.sv
// -----------------------------------------------------------------------------
// mole_scheduler_if
// Bundles the scheduler's game-side signals.
//   enable, difficulty_level, hit_btn           : game controller -> scheduler
//   mole_active, mole_id, hit_pulse, miss_pulse,
//   wrong_pulse, hit_flash                      : scheduler -> LEDs / score
// master = driving side (game controller), slave = the scheduler itself.
// -----------------------------------------------------------------------------
interface mole_scheduler_if #(
    parameter int N_HOLES = 8
);
    localparam int ID_W = $clog2(N_HOLES);

    logic               enable;
    logic [1:0]         difficulty_level;
    logic [N_HOLES-1:0] hit_btn;
    logic [N_HOLES-1:0] mole_active;
    logic [ID_W-1:0]    mole_id;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               wrong_pulse;
    logic               hit_flash;

    modport master (
        output enable, difficulty_level, hit_btn,
        input  mole_active, mole_id, hit_pulse, miss_pulse, wrong_pulse, hit_flash
    );

    modport slave (
        input  enable, difficulty_level, hit_btn,
        output mole_active, mole_id, hit_pulse, miss_pulse, wrong_pulse, hit_flash
    );

endinterface

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// Free-running 16-bit Galois LFSR used to pick the next hole.
//   clk   : system clock
//   rst   : asynchronous active-high reset, loads SEED
//   value : current LFSR state
// -----------------------------------------------------------------------------
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    // Shift right; when the bit falling out is 1, fold the tap mask back in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (value[0]) begin
            value <= (value >> 1) ^ LFSR_TAPS;
        end else begin
            value <= value >> 1;
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// -----------------------------------------------------------------------------
// mole_scheduler
// Pops moles up in pseudo-random holes while gameplay is enabled and
// classifies button presses into hit / wrong / miss pulses.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : mole_scheduler_if.slave (enable, difficulty_level, hit_btn in;
//         mole_active, mole_id, hit/miss/wrong pulses, hit_flash out)
// All outputs are registered; they are computed from the next state so that
// mole_active is lit on the very first UP cycle.
// -----------------------------------------------------------------------------
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int          N_HOLES      = 8,
    parameter int          TICKS_PER_MS = DEF_TICKS_PER_MS,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          UP_MS_EASY   = DEF_UP_MS_EASY,
    parameter int          UP_MS_MED    = DEF_UP_MS_MED,
    parameter int          UP_MS_HARD   = DEF_UP_MS_HARD,
    parameter int          GAP_MS       = DEF_GAP_MS,
    parameter int          WHACK_MS     = DEF_WHACK_MS
) (
    input  logic           clk,
    input  logic           rst,
    mole_scheduler_if.slave bus
);

    localparam int ID_W  = $clog2(N_HOLES);
    localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

    mole_state_t        state, state_n;
    logic [PRE_W-1:0]   pre_cnt;
    logic [MS_W-1:0]    ms_cnt;
    logic [MS_W-1:0]    cur_dur;
    logic [MS_W-1:0]    up_ms, up_ms_n;
    logic [ID_W-1:0]    mole_id, id_n, cand;
    logic [N_HOLES-1:0] active, active_n;
    logic               hit, hit_n;
    logic               miss, miss_n;
    logic               wrong, wrong_n;
    logic               flash, flash_n;
    logic               done;
    logic [15:0]        lfsr;
    logic               lfsr_unused;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // Only the low bits choose a hole; the rest just keeps the sequence long.
    assign lfsr_unused = ^lfsr[15:ID_W];

    function automatic logic [MS_W-1:0] up_time(input logic [1:0] d);
        case (d)
            DIFF_EASY: return MS_W'(UP_MS_EASY);
            DIFF_MED:  return MS_W'(UP_MS_MED);
            default:   return MS_W'(UP_MS_HARD);
        endcase
    endfunction

    // Duration of the current state and the final-cycle strobe.
    always_comb begin
        cur_dur = MS_W'(1);
        case (state)
            GAP:     cur_dur = MS_W'(GAP_MS);
            UP:      cur_dur = up_ms;
            WHACKED: cur_dur = MS_W'(WHACK_MS);
            default: cur_dur = MS_W'(1);
        endcase
        done = (pre_cnt == PRE_LAST) && (ms_cnt == cur_dur - MS_W'(1));
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n  = state;
        id_n     = mole_id;
        up_ms_n  = up_ms;
        active_n = active;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        wrong_n  = 1'b0;
        flash_n  = 1'b0;
        cand     = lfsr[ID_W-1:0];

        if (!bus.enable) begin
            state_n  = IDLE;
            active_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = GAP;
                    active_n = '0;
                end
                GAP: begin
                    active_n = '0;
                    if (done) begin
                        // Never relight the hole that was just used.
                        if (cand == mole_id) begin
                            cand = cand + ID_W'(1);
                        end
                        id_n     = cand;
                        up_ms_n  = up_time(bus.difficulty_level);
                        active_n = N_HOLES'(1) << cand;
                        state_n  = UP;
                    end
                end
                UP: begin
                    // A correct press outranks both a wrong press and timeout.
                    if (bus.hit_btn[mole_id]) begin
                        hit_n    = 1'b1;
                        active_n = '0;
                        flash_n  = 1'b1;
                        state_n  = WHACKED;
                    end else begin
                        wrong_n = |bus.hit_btn;
                        if (done) begin
                            miss_n   = 1'b1;
                            active_n = '0;
                            state_n  = GAP;
                        end
                    end
                end
                WHACKED: begin
                    active_n = '0;
                    if (done) begin
                        state_n = GAP;
                    end else begin
                        flash_n = 1'b1;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    active_n = '0;
                end
            endcase
        end
    end

    // Prescaler and millisecond counter restart on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (state_n != state) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            ms_cnt  <= ms_cnt + MS_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // State, latched mole parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mole_id <= '0;
            up_ms   <= '0;
            active  <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            wrong   <= 1'b0;
            flash   <= 1'b0;
        end else begin
            state   <= state_n;
            mole_id <= id_n;
            up_ms   <= up_ms_n;
            active  <= active_n;
            hit     <= hit_n;
            miss    <= miss_n;
            wrong   <= wrong_n;
            flash   <= flash_n;
        end
    end

    assign bus.mole_active = active;
    assign bus.mole_id     = mole_id;
    assign bus.hit_pulse   = hit;
    assign bus.miss_pulse  = miss;
    assign bus.wrong_pulse = wrong;
    assign bus.hit_flash   = flash;

endmodule
